// File: rtl/fighter_pkg.sv
// Shared types and constants for the fighter move sequencer.
// Player key maps, frame lengths and attack windows live here so both players agree.
package fighter_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WALK_L  = 3'd1,
        WALK_R  = 3'd2,
        JUMP    = 3'd3,
        PUNCH   = 3'd4,
        KICK    = 3'd5,
        HITSTUN = 3'd6
    } action_t;

    localparam logic [7:0] P1_KEY_LEFT  = 8'h04;
    localparam logic [7:0] P1_KEY_RIGHT = 8'h07;
    localparam logic [7:0] P1_KEY_JUMP  = 8'h1A;
    localparam logic [7:0] P1_KEY_PUNCH = 8'h09;
    localparam logic [7:0] P1_KEY_KICK  = 8'h0A;

    localparam logic [7:0] P2_KEY_LEFT  = 8'h50;
    localparam logic [7:0] P2_KEY_RIGHT = 8'h4F;
    localparam logic [7:0] P2_KEY_JUMP  = 8'h52;
    localparam logic [7:0] P2_KEY_PUNCH = 8'h10;
    localparam logic [7:0] P2_KEY_KICK  = 8'h11;

    localparam int DEF_WALK_SPEED     = 2;
    localparam int DEF_PUNCH_FRAMES   = 12;
    localparam int DEF_KICK_FRAMES    = 16;
    localparam int DEF_JUMP_FRAMES    = 32;
    localparam int DEF_JUMP_RISE      = 4;
    localparam int DEF_HITSTUN_FRAMES = 20;

    localparam int PUNCH_HIT_FIRST = 4;
    localparam int PUNCH_HIT_LAST  = 7;
    localparam int KICK_HIT_FIRST  = 6;
    localparam int KICK_HIT_LAST   = 10;

endpackage

// File: rtl/fighter_action_seq_key_match.sv
// Flags a key as pressed when any of the four USB keycode slots carries its HID code.
// KEY is never 8'h00, so empty slots can never match.
module key_match #(
    parameter logic [7:0] KEY = 8'h04
) (
    input  logic [7:0] keycode0_i,
    input  logic [7:0] keycode1_i,
    input  logic [7:0] keycode2_i,
    input  logic [7:0] keycode3_i,
    output logic       pressed_o
);

    assign pressed_o = (keycode0_i == KEY) | (keycode1_i == KEY) |
                       (keycode2_i == KEY) | (keycode3_i == KEY);

endmodule

// File: rtl/fighter_action_seq.sv
// Per-player action state machine stepped once per video frame (falling edge of vs).
// All outputs are registered and derived from the next state on the tick cycle.
module fighter_action_seq
    import fighter_pkg::*;
#(
    parameter logic [7:0] KEY_LEFT       = P1_KEY_LEFT,
    parameter logic [7:0] KEY_RIGHT      = P1_KEY_RIGHT,
    parameter logic [7:0] KEY_JUMP       = P1_KEY_JUMP,
    parameter logic [7:0] KEY_PUNCH      = P1_KEY_PUNCH,
    parameter logic [7:0] KEY_KICK       = P1_KEY_KICK,
    parameter int         WALK_SPEED     = DEF_WALK_SPEED,
    parameter int         PUNCH_FRAMES   = DEF_PUNCH_FRAMES,
    parameter int         KICK_FRAMES    = DEF_KICK_FRAMES,
    parameter int         JUMP_FRAMES    = DEF_JUMP_FRAMES,
    parameter int         JUMP_RISE      = DEF_JUMP_RISE,
    parameter int         HITSTUN_FRAMES = DEF_HITSTUN_FRAMES
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              vs,
    input  logic [7:0]        keycode_0,
    input  logic [7:0]        keycode_1,
    input  logic [7:0]        keycode_2,
    input  logic [7:0]        keycode_3,
    input  logic              hit_in,
    output logic [2:0]        action,
    output logic [2:0]        anim_frame,
    output logic signed [3:0] x_step,
    output logic [6:0]        y_offset,
    output logic              hitbox_active,
    output logic              busy
);

    localparam logic signed [3:0] STEP_R = 4'(WALK_SPEED);
    localparam logic signed [3:0] STEP_L = -STEP_R;
    localparam logic [4:0] P_LO = 5'(PUNCH_HIT_FIRST);
    localparam logic [4:0] P_HI = 5'(PUNCH_HIT_LAST);
    localparam logic [4:0] K_LO = 5'(KICK_HIT_FIRST);
    localparam logic [4:0] K_HI = 5'(KICK_HIT_LAST);

    logic left, right, jump, punch, kick;

    key_match #(.KEY(KEY_LEFT))  u_left  (.keycode0_i(keycode_0), .keycode1_i(keycode_1), .keycode2_i(keycode_2), .keycode3_i(keycode_3), .pressed_o(left));
    key_match #(.KEY(KEY_RIGHT)) u_right (.keycode0_i(keycode_0), .keycode1_i(keycode_1), .keycode2_i(keycode_2), .keycode3_i(keycode_3), .pressed_o(right));
    key_match #(.KEY(KEY_JUMP))  u_jump  (.keycode0_i(keycode_0), .keycode1_i(keycode_1), .keycode2_i(keycode_2), .keycode3_i(keycode_3), .pressed_o(jump));
    key_match #(.KEY(KEY_PUNCH)) u_punch (.keycode0_i(keycode_0), .keycode1_i(keycode_1), .keycode2_i(keycode_2), .keycode3_i(keycode_3), .pressed_o(punch));
    key_match #(.KEY(KEY_KICK))  u_kick  (.keycode0_i(keycode_0), .keycode1_i(keycode_1), .keycode2_i(keycode_2), .keycode3_i(keycode_3), .pressed_o(kick));

    action_t           action_q, action_d;
    logic [4:0]        frame_cnt_q, frame_cnt_d;
    logic signed [3:0] jdir_q, jdir_d;
    logic              vs_q, hit_pend_q, hit_pend_d, tick;
    logic signed [3:0] walk_dir;
    logic [2:0]        anim_q, anim_d;
    logic signed [3:0] x_step_q, x_step_d;
    logic [6:0]        y_q, y_d;
    logic              hitbox_q, hitbox_d, busy_q, busy_d;

    function automatic logic [4:0] last_frame(input action_t a);
        case (a)
            JUMP:    return 5'(JUMP_FRAMES - 1);
            PUNCH:   return 5'(PUNCH_FRAMES - 1);
            KICK:    return 5'(KICK_FRAMES - 1);
            HITSTUN: return 5'(HITSTUN_FRAMES - 1);
            default: return 5'd0;
        endcase
    endfunction

    // Symmetric arc: climbs from 0 to the peak at the midpoint frame, lands at one rise step.
    function automatic logic [6:0] jump_y(input logic [4:0] fc);
        int f;
        f = int'(fc);
        if (f < JUMP_FRAMES / 2) return 7'(f * JUMP_RISE);
        return 7'((JUMP_FRAMES - f) * JUMP_RISE);
    endfunction

    assign tick       = vs_q & ~vs;
    assign hit_pend_d = hit_in | (hit_pend_q & ~tick);
    assign walk_dir   = (left ^ right) ? (right ? STEP_R : STEP_L) : 4'sd0;

    always_comb begin
        action_d    = action_q;
        frame_cnt_d = frame_cnt_q;
        jdir_d      = jdir_q;
        if (hit_pend_q && action_q != HITSTUN) begin
            action_d    = HITSTUN;
            frame_cnt_d = 5'd0;
        end else begin
            case (action_q)
                JUMP, PUNCH, KICK, HITSTUN: begin
                    if (frame_cnt_q == last_frame(action_q)) begin
                        action_d    = IDLE;
                        frame_cnt_d = 5'd0;
                    end else begin
                        frame_cnt_d = frame_cnt_q + 5'd1;
                    end
                end
                default: begin
                    if (punch)              action_d = PUNCH;
                    else if (kick)          action_d = KICK;
                    else if (jump) begin
                        action_d = JUMP;
                        jdir_d   = walk_dir;
                    end
                    else if (left ^ right)  action_d = right ? WALK_R : WALK_L;
                    else                    action_d = IDLE;
                    frame_cnt_d = (action_d == action_q && action_d != IDLE) ? frame_cnt_q + 5'd1 : 5'd0;
                end
            endcase
        end

        case (action_d)
            WALK_R:  x_step_d = STEP_R;
            WALK_L:  x_step_d = STEP_L;
            JUMP:    x_step_d = jdir_d;
            default: x_step_d = 4'sd0;
        endcase
        y_d      = (action_d == JUMP) ? jump_y(frame_cnt_d) : 7'd0;
        anim_d   = (action_d == HITSTUN) ? 3'd0 : frame_cnt_d[4:2];
        hitbox_d = (action_d == PUNCH && frame_cnt_d >= P_LO && frame_cnt_d <= P_HI) ||
                   (action_d == KICK  && frame_cnt_d >= K_LO && frame_cnt_d <= K_HI);
        busy_d   = action_d inside {JUMP, PUNCH, KICK, HITSTUN};
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            vs_q        <= 1'b1;
            hit_pend_q  <= 1'b0;
            action_q    <= IDLE;
            frame_cnt_q <= 5'd0;
            jdir_q      <= 4'sd0;
            anim_q      <= 3'd0;
            x_step_q    <= 4'sd0;
            y_q         <= 7'd0;
            hitbox_q    <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            vs_q       <= vs;
            hit_pend_q <= hit_pend_d;
            if (tick) begin
                action_q    <= action_d;
                frame_cnt_q <= frame_cnt_d;
                jdir_q      <= jdir_d;
                anim_q      <= anim_d;
                x_step_q    <= x_step_d;
                y_q         <= y_d;
                hitbox_q    <= hitbox_d;
                busy_q      <= busy_d;
            end
        end
    end

    assign action        = action_q;
    assign anim_frame    = anim_q;
    assign x_step        = x_step_q;
    assign y_offset      = y_q;
    assign hitbox_active = hitbox_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_fighter_action_seq.sv
// Scoreboard bench for fighter_action_seq: each generated frame queues its expected outputs,
// and a monitor compares them one cycle after the vs falling edge is seen.
module tb_fighter_action_seq;

    logic              Clk = 1'b0;
    logic              Reset;
    logic              vs;
    logic [7:0]        kc0, kc1, kc2, kc3;
    logic              hit_in;
    logic [2:0]        action, anim_frame;
    logic signed [3:0] x_step;
    logic [6:0]        y_offset;
    logic              hitbox_active, busy;

    typedef struct packed {
        logic [2:0] act;
        logic [2:0] anim;
        logic [3:0] x;
        logic [6:0] y;
        logic       hb;
        logic       busy;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   frame_no = 0;
    logic tb_vs_q, tick_fired;

    localparam logic [3:0] XP = 4'd2;
    localparam logic [3:0] XM = 4'hE;
    localparam logic [3:0] X0 = 4'd0;

    fighter_action_seq dut (
        .Clk(Clk), .Reset(Reset), .vs(vs),
        .keycode_0(kc0), .keycode_1(kc1), .keycode_2(kc2), .keycode_3(kc3),
        .hit_in(hit_in), .action(action), .anim_frame(anim_frame), .x_step(x_step),
        .y_offset(y_offset), .hitbox_active(hitbox_active), .busy(busy)
    );

    always #5 Clk = ~Clk;

    function automatic exp_t E(input int a, input int anim, input logic [3:0] x,
                               input int y, input logic hb, input logic b);
        exp_t e;
        e.act = 3'(a); e.anim = 3'(anim); e.x = x; e.y = 7'(y); e.hb = hb; e.busy = b;
        return e;
    endfunction

    function automatic exp_t got_now();
        return E(int'(action), int'(anim_frame), x_step, int'(y_offset), hitbox_active, busy);
    endfunction

    function automatic exp_t jexp(input int k, input logic [3:0] x);
        return E(3, k / 4, x, (k < 16) ? 4 * k : 4 * (32 - k), 1'b0, 1'b1);
    endfunction

    task automatic report(input string name, input exp_t g, input exp_t e);
        $display("FAIL %s: got act=%0d anim=%0d x=%0d y=%0d hb=%0d busy=%0d, want act=%0d anim=%0d x=%0d y=%0d hb=%0d busy=%0d",
                 name, g.act, g.anim, $signed(g.x), g.y, g.hb, g.busy,
                 e.act, e.anim, $signed(e.x), e.y, e.hb, e.busy);
    endtask

    // Bench copy of the tick detector marks which edges must be checked.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            tb_vs_q    <= 1'b1;
            tick_fired <= 1'b0;
        end else begin
            tb_vs_q    <= vs;
            tick_fired <= tb_vs_q & ~vs;
        end
    end

    always @(negedge Clk) begin
        if (!Reset && tick_fired) begin
            exp_t e, g;
            frame_no++;
            n_checks++;
            g = got_now();
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_tick frame %0d: got act=%0d, want no tick", frame_no, g.act);
            end else begin
                e = sb.pop_front();
                if (g !== e) begin
                    n_fail++;
                    report($sformatf("frame%0d", frame_no), g, e);
                end
            end
        end
    end

    task automatic frame(input exp_t e);
        sb.push_back(e);
        @(negedge Clk) vs = 1'b0;
        @(negedge Clk);
        @(negedge Clk) vs = 1'b1;
        repeat (4) @(negedge Clk);
    endtask

    task automatic hit_pulse();
        @(negedge Clk) hit_in = 1'b1;
        @(negedge Clk) hit_in = 1'b0;
    endtask

    task automatic check_now(input string name, input exp_t e);
        exp_t g;
        g = got_now();
        n_checks++;
        if (g !== e) begin
            n_fail++;
            report(name, g, e);
        end
    endtask

    task automatic keys(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic [7:0] d);
        kc0 = a; kc1 = b; kc2 = c; kc3 = d;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish, want finish before time limit");
        $fatal(1);
    end

    initial begin
        Reset = 1'b1; vs = 1'b1; hit_in = 1'b0;
        keys(8'h00, 8'h00, 8'h00, 8'h00);
        repeat (3) @(negedge Clk);
        check_now("reset_state", E(0, 0, X0, 0, 0, 0));
        Reset = 1'b0;

        repeat (3) frame(E(0, 0, X0, 0, 0, 0));

        keys(8'h00, 8'h00, 8'h07, 8'h00);
        for (int k = 0; k < 5; k++) frame(E(2, k / 4, XP, 0, 0, 0));
        keys(8'h00, 8'h00, 8'h00, 8'h00);
        frame(E(0, 0, X0, 0, 0, 0));

        keys(8'h09, 8'h00, 8'h00, 8'h00);
        frame(E(4, 0, X0, 0, 0, 1));
        keys(8'h00, 8'h00, 8'h00, 8'h00);
        for (int k = 1; k < 12; k++) frame(E(4, k / 4, X0, 0, (k >= 4 && k <= 7), 1));
        frame(E(0, 0, X0, 0, 0, 0));

        // Full jump, then the exit tick ignores still-held keys, then a hit at frame 10.
        keys(8'h00, 8'h04, 8'h00, 8'h1A);
        for (int k = 0; k < 32; k++) frame(jexp(k, XM));
        frame(E(0, 0, X0, 0, 0, 0));
        for (int k = 0; k <= 10; k++) frame(jexp(k, XM));
        hit_pulse();
        keys(8'h00, 8'h00, 8'h00, 8'h00);
        frame(E(6, 0, X0, 0, 0, 1));
        hit_pulse();
        for (int k = 1; k < 20; k++) frame(E(6, 0, X0, 0, 0, 1));
        frame(E(0, 0, X0, 0, 0, 0));

        keys(8'h0A, 8'h00, 8'h00, 8'h00);
        frame(E(5, 0, X0, 0, 0, 1));
        keys(8'h00, 8'h00, 8'h00, 8'h00);
        for (int k = 1; k <= 7; k++) frame(E(5, k / 4, X0, 0, (k >= 6 && k <= 10), 1));
        #2 Reset = 1'b1;
        #1 check_now("async_reset_mid_kick", E(0, 0, X0, 0, 0, 0));
        @(negedge Clk) Reset = 1'b0;
        keys(8'h00, 8'h00, 8'h07, 8'h00);
        frame(E(2, 0, XP, 0, 0, 0));
        keys(8'h00, 8'h00, 8'h00, 8'h00);
        frame(E(0, 0, X0, 0, 0, 0));

        keys(8'h09, 8'h0A, 8'h00, 8'h00);
        frame(E(4, 0, X0, 0, 0, 1));
        keys(8'h00, 8'h00, 8'h00, 8'h00);
        for (int k = 1; k < 12; k++) frame(E(4, k / 4, X0, 0, (k >= 4 && k <= 7), 1));
        frame(E(0, 0, X0, 0, 0, 0));

        keys(8'h04, 8'h07, 8'h00, 8'h00);
        frame(E(0, 0, X0, 0, 0, 0));
        keys(8'h04, 8'h07, 8'h1A, 8'h00);
        frame(jexp(0, X0));
        keys(8'h00, 8'h00, 8'h00, 8'h00);
        for (int k = 1; k < 32; k++) frame(jexp(k, X0));
        frame(E(0, 0, X0, 0, 0, 0));

        keys(8'h00, 8'h00, 8'h00, 8'h04);
        frame(E(1, 0, XM, 0, 0, 0));
        frame(E(1, 0, XM, 0, 0, 0));
        keys(8'h00, 8'h00, 8'h00, 8'h00);
        frame(E(0, 0, X0, 0, 0, 0));

        repeat (3) @(negedge Clk);
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
